// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS datapath: ALU functions, control-field codes,
// funct and opcode constants.
package mc_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_fn_e;

    // alu_op field
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    // alu_src_b field
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // pc_source field
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_alu_ctrl.sv
// ALU-control decode: maps the FSM's alu_op field and the instruction funct to an ALU function.
module mc_alu_ctrl
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_fn_e    alu_fn
);

    always_comb begin
        alu_fn = ALU_ADD;
        unique case (alu_op)
            ALUOP_ADD:  alu_fn = ALU_ADD;
            ALUOP_SUB:  alu_fn = ALU_SUB;
            ALUOP_ADD2: alu_fn = ALU_ADD;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_fn = ALU_ADD;
                    FN_SUB:  alu_fn = ALU_SUB;
                    FN_AND:  alu_fn = ALU_AND;
                    FN_OR:   alu_fn = ALU_OR;
                    FN_NOR:  alu_fn = ALU_NOR;
                    FN_SLT:  alu_fn = ALU_SLT;
                    default: alu_fn = ALU_ADD;
                endcase
            end
            default: alu_fn = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath: PC/IR/MDR/A/B/ALUOut registers, ALU and PC-next logic.
// Define MC_DP_OVF_EN to enable the signed-overflow flag on add/sub.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        iord,
    input  logic        ir_write,
    input  logic        mem_to_reg,
    input  logic        reg_dst,
    input  logic        alu_src_a,
    input  logic [1:0]  alu_src_b,
    input  logic [1:0]  alu_op,
    input  logic [1:0]  pc_source,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [5:0]  op,
    output logic        zero,
    output logic        ovf
);

    logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0] imm_ext;
    logic [31:0] src_a, src_b, alu_res;
    logic [31:0] pc_next;
    logic        pc_en;
    alu_fn_e     alu_fn;

    mc_alu_ctrl u_alu_ctrl (
        .alu_op (alu_op),
        .funct  (ir_q[5:0]),
        .alu_fn (alu_fn)
    );

    assign imm_ext = sext16(ir_q[15:0]);
    assign src_a   = alu_src_a ? a_q : pc_q;

    always_comb begin
        src_b = b_q;
        unique case (alu_src_b)
            SRCB_REG:    src_b = b_q;
            SRCB_FOUR:   src_b = 32'd4;
            SRCB_IMM:    src_b = imm_ext;
            SRCB_IMM_SH: src_b = {imm_ext[29:0], 2'b00};
            default:     src_b = b_q;
        endcase
    end

    always_comb begin
        alu_res = src_a + src_b;
        case (alu_fn)
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_NOR: alu_res = ~(src_a | src_b);
            ALU_SLT: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_res = src_a + src_b;
        endcase
    end

    assign zero = (alu_res == 32'd0);

`ifdef MC_DP_OVF_EN
    // Overflow when operands (B inverted for sub) agree in sign but the result does not.
    logic ovf_add, ovf_sub;
    assign ovf_add = (src_a[31] == src_b[31]) && (alu_res[31] != src_a[31]);
    assign ovf_sub = (src_a[31] != src_b[31]) && (alu_res[31] != src_a[31]);
    assign ovf     = ((alu_fn == ALU_ADD) && ovf_add) || ((alu_fn == ALU_SUB) && ovf_sub);
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        pc_next = pc_q;
        unique case (pc_source)
            PCSRC_ALU:    pc_next = alu_res;
            PCSRC_ALUOUT: pc_next = aluout_q;
            PCSRC_JUMP:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
            PCSRC_HOLD:   pc_next = pc_q;
            default:      pc_next = pc_q;
        endcase
    end

    // pc_write dominates; the conditional load only matters when pc_write is low.
    assign pc_en = pc_write | (pc_write_cond & zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            mdr_q    <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
        end else begin
            if (pc_en) begin
                pc_q <= pc_next;
            end
            if (ir_write) begin
                ir_q <= mem_rdata;
            end
            mdr_q    <= mem_rdata;
            a_q      <= rf_rdata1;
            b_q      <= rf_rdata2;
            aluout_q <= alu_res;
        end
    end

    assign mem_addr  = iord ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign rf_raddr1 = ir_q[25:21];
    assign rf_raddr2 = ir_q[20:16];
    assign rf_waddr  = reg_dst ? ir_q[15:11] : ir_q[20:16];
    assign rf_wdata  = mem_to_reg ? mdr_q : aluout_q;
    assign op        = ir_q[31:26];

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed scenarios plus randomized cycles against a
// behavioural model of the datapath registers.
module tb_mc_datapath;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, pc_write_cond, iord, ir_write, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] mem_rdata, mem_addr, mem_wdata, rf_rdata1, rf_rdata2, rf_wdata;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [5:0]  op;
    logic        zero, ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;

    always #5 clk = ~clk;

    mc_datapath #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .op            (op),
        .zero          (zero),
        .ovf           (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt
    function automatic int ref_kind(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'b01) return 1;
        if (aop != 2'b10) return 0;
        case (fn)
            6'h22:   return 1;
            6'h24:   return 2;
            6'h25:   return 3;
            6'h27:   return 4;
            6'h2A:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            1:       return a - b;
            2:       return a & b;
            3:       return a | b;
            4:       return ~(a | b);
            5:       return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; iord = 0; ir_write = 0; mem_to_reg = 0; reg_dst = 0;
        alu_src_a = 0; alu_src_b = 2'b00; alu_op = 2'b00; pc_source = 2'b11;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
    endtask

    // One clock cycle: compare all outputs to the model, then advance model and DUT together.
    task automatic step();
        logic [31:0] imm, opa, opb, res, pcn;
        logic        e_ovf;
        int          k;
        longint      s;
        imm = {{16{m_ir[15]}}, m_ir[15:0]};
        opa = alu_src_a ? m_a : m_pc;
        case (alu_src_b)
            2'b00:   opb = m_b;
            2'b01:   opb = 32'd4;
            2'b10:   opb = imm;
            default: opb = imm * 4;
        endcase
        k   = ref_kind(alu_op, m_ir[5:0]);
        res = ref_alu(k, opa, opb);
        e_ovf = 1'b0;
`ifdef MC_DP_OVF_EN
        if (k == 0 || k == 1) begin
            s = (k == 0) ? longint'(int'(opa)) + longint'(int'(opb))
                         : longint'(int'(opa)) - longint'(int'(opb));
            e_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
`else
        s = 0;
`endif
        #1;
        check("mem_addr", mem_addr, iord ? m_aluout : m_pc);
        check("mem_wdata", mem_wdata, m_b);
        check("rf_raddr1", 32'(rf_raddr1), 32'(m_ir[25:21]));
        check("rf_raddr2", 32'(rf_raddr2), 32'(m_ir[20:16]));
        check("rf_waddr", 32'(rf_waddr), reg_dst ? 32'(m_ir[15:11]) : 32'(m_ir[20:16]));
        check("rf_wdata", rf_wdata, mem_to_reg ? m_mdr : m_aluout);
        check("op", 32'(op), 32'(m_ir[31:26]));
        check("zero", 32'(zero), 32'(res == 0));
        check("ovf", 32'(ovf), 32'(e_ovf));
        case (pc_source)
            2'b00:   pcn = res;
            2'b01:   pcn = m_aluout;
            2'b10:   pcn = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: pcn = m_pc;
        endcase
        @(posedge clk);
        if (pc_write || (pc_write_cond && res == 0)) m_pc = pcn;
        if (ir_write) m_ir = mem_rdata;
        m_mdr = mem_rdata; m_a = rf_rdata1; m_b = rf_rdata2; m_aluout = res;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        model_reset();
        check("rst_pc", mem_addr, RST_PC);
        check("rst_op", 32'(op), 32'd0);
        check("rst_aluout", rf_wdata, 32'd0);
        check("rst_b", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic fetch(input logic [31:0] instr);
        idle();
        pc_write = 1; ir_write = 1; alu_src_b = 2'b01; pc_source = 2'b00; mem_rdata = instr;
        step();
    endtask

    task automatic beq_case(input logic [31:0] bval, input logic [31:0] exp_pc, input string tag);
        do_reset();
        fetch(32'h1000_FFFE);
        idle(); alu_src_b = 2'b11; rf_rdata1 = 32'd5; rf_rdata2 = bval;
        step();
        idle(); #1;
        check({tag, "_target"}, rf_wdata, 32'h3C);
        alu_src_a = 1; alu_op = 2'b01; pc_write_cond = 1; pc_source = 2'b01;
        step();
        idle(); #1;
        check({tag, "_pc"}, mem_addr, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; mem_rdata = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        idle();
        @(negedge clk);
        do_reset();

        // Fetch lw $3, 8($2)
        fetch(32'h8C43_0008);
        idle(); #1;
        check("fetch_pc", mem_addr, 32'h44);
        check("fetch_op", 32'(op), 32'h23);
        check("fetch_rs", 32'(rf_raddr1), 32'd2);

        // lw address calc, memory read, write-back
        rf_rdata1 = 32'h100;
        step();
        idle(); alu_src_a = 1; alu_src_b = 2'b10;
        step();
        #1 check("lw_aluout", rf_wdata, 32'h108);
        iord = 1; mem_rdata = 32'hDEAD_BEEF;
        #1 check("lw_addr", mem_addr, 32'h108);
        step();
        idle(); mem_to_reg = 1; #1;
        check("lw_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("lw_waddr", 32'(rf_waddr), 32'd3);

        beq_case(32'd5, 32'h3C, "beq_taken");
        beq_case(32'd6, 32'h44, "beq_not_taken");

        // j with PC upper nibble 4
        do_reset();
        fetch(32'h0800_0010);
        idle(); rf_rdata1 = 32'h4000_0004; rf_rdata2 = 0;
        step();
        idle(); alu_src_a = 1; pc_write = 1; pc_source = 2'b00;
        step();
        idle(); #1 check("j_setup_pc", mem_addr, 32'h4000_0004);
        pc_write = 1; pc_source = 2'b10;
        step();
        idle(); #1 check("j_pc", mem_addr, 32'h4000_0040);

        // slt then nor
        do_reset();
        fetch(32'h0022_182A);
        idle(); rf_rdata1 = 32'hFFFF_FFFF; rf_rdata2 = 32'd1;
        step();
        idle(); alu_src_a = 1; alu_op = 2'b10;
        #1 check("slt_zero", 32'(zero), 32'd0);
        step();
        idle(); #1 check("slt_res", rf_wdata, 32'd1);
        ir_write = 1; mem_rdata = 32'h0000_0027; rf_rdata1 = 0; rf_rdata2 = 0;
        step();
        idle(); alu_src_a = 1; alu_op = 2'b10;
        #1 check("nor_zero", 32'(zero), 32'd0);
        step();
        idle(); #1 check("nor_res", rf_wdata, 32'hFFFF_FFFF);

        // Overflow flag on 7FFF_FFFF + 1
        rf_rdata1 = 32'h7FFF_FFFF; rf_rdata2 = 32'd1;
        step();
        alu_src_a = 1; alu_op = 2'b00;
`ifdef MC_DP_OVF_EN
        #1 check("ovf_add", 32'(ovf), 32'd1);
`else
        #1 check("ovf_off", 32'(ovf), 32'd0);
`endif
        step();

        // Asynchronous reset mid-instruction with pc_write held
        fetch(32'h0000_0020);
        idle(); pc_write = 1; pc_source = 2'b01;
        #2;
        rst_n = 0;
        #1 check("async_rst_pc", mem_addr, RST_PC);
        check("async_rst_op", 32'(op), 32'd0);
        @(posedge clk); #1;
        check("rst_hold_pc", mem_addr, RST_PC);
        @(negedge clk);
        model_reset();
        rst_n = 1;

        // Randomized cycles against the model
        for (int i = 0; i < 400; i++) begin
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = $urandom_range(0, 1);
            iord          = $urandom_range(0, 1);
            ir_write      = ($urandom_range(0, 3) == 0);
            mem_to_reg    = $urandom_range(0, 1);
            reg_dst       = $urandom_range(0, 1);
            alu_src_a     = $urandom_range(0, 1);
            alu_src_b     = 2'($urandom_range(0, 3));
            alu_op        = 2'($urandom_range(0, 3));
            pc_source     = 2'($urandom_range(0, 3));
            mem_rdata     = $urandom;
            // Bias funct toward the decoded set and operands toward equality
            if ($urandom_range(0, 1) == 1) mem_rdata[5:0] = 6'h20 + 6'($urandom_range(0, 10));
            rf_rdata1 = $urandom;
            rf_rdata2 = ($urandom_range(0, 3) == 0) ? rf_rdata1 : $urandom;
            if ($urandom_range(0, 7) == 0) rf_rdata1 = 32'h7FFF_FFFF;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
